// File: rtl/load_align_unit_if.sv
// Request, data-bus and response signals of the load align unit.
interface load_align_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [2:0]        req_funct3;
  logic              flush;
  logic              bus_req;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN/8-1:0] bus_strobe;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_funct3, flush, bus_gnt, bus_rvalid, bus_rdata,
    output req_ready, bus_req, bus_addr, bus_strobe, rsp_valid, rsp_data, rsp_fault
  );

  modport master (
    output req_valid, req_addr, req_funct3, flush, bus_gnt, bus_rvalid, bus_rdata,
    input  req_ready, bus_req, bus_addr, bus_strobe, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load unit: issues one or two aligned bus beats per load, merges
// them and applies byte/half/word/double extraction with sign/zero extension.
module load_align_unit #(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  load_align_unit_if.slave lau
);
  localparam int unsigned W  = XLEN / 8;
  localparam int unsigned LW = $clog2(W);
  localparam int unsigned SW = LW + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP, S_DRAIN
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_base, w_base_nxt;
  logic [LW-1:0]   r_off, w_off_nxt;
  logic [1:0]      r_sz, w_sz_nxt;
  logic            r_uns, w_uns_nxt;
  logic            r_split, w_split_nxt;
  logic [W-1:0]    r_strb1, w_strb1_nxt;
  logic [XLEN-1:0] r_rdata0, w_rdata0_nxt;
  logic            r_bus_req, w_bus_req_nxt;
  logic [XLEN-1:0] r_bus_addr, w_bus_addr_nxt;
  logic [W-1:0]    r_bus_strobe, w_bus_strobe_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic            r_rsp_fault, w_rsp_fault_nxt;
  logic [XLEN-1:0] r_rsp_data, w_rsp_data_nxt;

  logic            w_accept;
  logic            w_legal;
  logic            w_split;
  logic [3:0]      w_size;
  logic [LW-1:0]   w_req_off;
  logic [XLEN-1:0] w_req_base;
  logic [2*W-1:0]  w_mask;

  // Request decode: legality, lane offset, word crossing and two-beat strobe mask
  always_comb begin
    w_accept = lau.req_valid && (r_state == S_IDLE) && !lau.flush;
    case (lau.req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
      3'b011, 3'b110:                         w_legal = (XLEN == 64);
      default:                                w_legal = 1'b0;
    endcase
    w_size     = 4'(1) << lau.req_funct3[1:0];
    w_req_off  = lau.req_addr[LW-1:0];
    w_req_base = lau.req_addr & ~XLEN'(W - 1);
    w_split    = (5'(w_req_off) + 5'(w_size)) > 5'(W);
    for (int i = 0; i < int'(2 * W); i++) begin
      w_mask[i] = (i >= int'(w_req_off)) && (i < int'(w_req_off) + int'(w_size));
    end
  end

  logic [2*XLEN-1:0] w_cat;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_ext;
  logic [SW-1:0]     w_shamt;
  logic              w_sign;
  int                w_nbits;

  // Merge the returned beat(s), drop the leading bytes, then extend
  always_comb begin
    if (r_state == S_WAIT1) w_cat = {lau.bus_rdata, r_rdata0};
    else                    w_cat = {XLEN'(0), lau.bus_rdata};
    w_shamt   = {r_off, 3'b000};
    w_shifted = XLEN'(w_cat >> w_shamt);
    w_nbits   = int'(8) << r_sz;
    w_sign    = 1'b0;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i == w_nbits - 1) w_sign = w_shifted[i];
    end
    for (int i = 0; i < int'(XLEN); i++) begin
      w_ext[i] = (i < w_nbits) ? w_shifted[i] : (w_sign & ~r_uns);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_off_nxt        = r_off;
    w_sz_nxt         = r_sz;
    w_uns_nxt        = r_uns;
    w_split_nxt      = r_split;
    w_strb1_nxt      = r_strb1;
    w_rdata0_nxt     = r_rdata0;
    w_bus_req_nxt    = r_bus_req;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_strobe_nxt = r_bus_strobe;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_fault_nxt  = 1'b0;
    w_rsp_data_nxt   = r_rsp_data;
    case (r_state)
      S_IDLE: begin
        w_bus_req_nxt = 1'b0;
        if (w_accept) begin
          w_base_nxt  = w_req_base;
          w_off_nxt   = w_req_off;
          w_sz_nxt    = lau.req_funct3[1:0];
          w_uns_nxt   = lau.req_funct3[2];
          w_split_nxt = w_split;
          w_strb1_nxt = w_mask[2*W-1:W];
          if (!w_legal || (w_split && !MISALIGNED_EN)) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_fault_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
          end else begin
            w_state_nxt      = S_REQ0;
            w_bus_req_nxt    = 1'b1;
            w_bus_addr_nxt   = w_req_base;
            w_bus_strobe_nxt = w_mask[W-1:0];
          end
        end
      end
      S_REQ0, S_REQ1: begin
        if (lau.bus_gnt) begin
          w_bus_req_nxt = 1'b0;
          if (lau.flush)              w_state_nxt = S_DRAIN;
          else if (r_state == S_REQ0) w_state_nxt = S_WAIT0;
          else                        w_state_nxt = S_WAIT1;
        end else if (lau.flush) begin
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_WAIT0: begin
        // A flush that coincides with the data return has nothing left to drain
        if (lau.bus_rvalid) begin
          if (lau.flush) begin
            w_state_nxt = S_IDLE;
          end else if (r_split) begin
            w_state_nxt      = S_REQ1;
            w_rdata0_nxt     = lau.bus_rdata;
            w_bus_req_nxt    = 1'b1;
            w_bus_addr_nxt   = r_base + XLEN'(W);
            w_bus_strobe_nxt = r_strb1;
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = w_ext;
          end
        end else if (lau.flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_WAIT1: begin
        if (lau.bus_rvalid) begin
          if (lau.flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = w_ext;
          end
        end else if (lau.flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_DRAIN: if (lau.bus_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Load context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_off        <= '0;
      r_sz         <= '0;
      r_uns        <= 1'b0;
      r_split      <= 1'b0;
      r_strb1      <= '0;
      r_rdata0     <= '0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_strobe <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_fault  <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_base       <= w_base_nxt;
      r_off        <= w_off_nxt;
      r_sz         <= w_sz_nxt;
      r_uns        <= w_uns_nxt;
      r_split      <= w_split_nxt;
      r_strb1      <= w_strb1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_bus_req    <= w_bus_req_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_strobe <= w_bus_strobe_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_fault  <= w_rsp_fault_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
    end
  end

  // A flush landing on the response cycle still kills the pulse
  assign lau.req_ready  = (r_state == S_IDLE);
  assign lau.bus_req    = r_bus_req;
  assign lau.bus_addr   = r_bus_addr;
  assign lau.bus_strobe = r_bus_strobe;
  assign lau.rsp_valid  = r_rsp_valid & ~lau.flush;
  assign lau.rsp_fault  = r_rsp_fault & ~lau.flush;
  assign lau.rsp_data   = r_rsp_data;
endmodule

// File: tb/tb_load_align_unit.sv
// Randomized bench for load_align_unit: three configurations share one driver,
// checked against a byte-addressed memory model.
module tb_load_align_unit;
  logic clk;
  logic rst_n;
  always #5 clk = ~clk;

  // sel 0: XLEN=32 split enabled; 1: XLEN=32 split faults; 2: XLEN=64 split enabled
  int          sel;
  logic        t_req_valid, t_flush, t_gnt, t_rvalid;
  logic [63:0] t_addr, t_rdata;
  logic [2:0]  t_f3;

  load_align_unit_if #(.XLEN(32)) if_a ();
  load_align_unit_if #(.XLEN(32)) if_b ();
  load_align_unit_if #(.XLEN(64)) if_c ();

  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .lau(if_a));
  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .lau(if_b));
  load_align_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .lau(if_c));

  assign if_a.req_valid  = t_req_valid && (sel == 0);
  assign if_a.req_addr   = t_addr[31:0];
  assign if_a.req_funct3 = t_f3;
  assign if_a.flush      = t_flush && (sel == 0);
  assign if_a.bus_gnt    = t_gnt && (sel == 0);
  assign if_a.bus_rvalid = t_rvalid && (sel == 0);
  assign if_a.bus_rdata  = t_rdata[31:0];

  assign if_b.req_valid  = t_req_valid && (sel == 1);
  assign if_b.req_addr   = t_addr[31:0];
  assign if_b.req_funct3 = t_f3;
  assign if_b.flush      = t_flush && (sel == 1);
  assign if_b.bus_gnt    = t_gnt && (sel == 1);
  assign if_b.bus_rvalid = t_rvalid && (sel == 1);
  assign if_b.bus_rdata  = t_rdata[31:0];

  assign if_c.req_valid  = t_req_valid && (sel == 2);
  assign if_c.req_addr   = t_addr;
  assign if_c.req_funct3 = t_f3;
  assign if_c.flush      = t_flush && (sel == 2);
  assign if_c.bus_gnt    = t_gnt && (sel == 2);
  assign if_c.bus_rvalid = t_rvalid && (sel == 2);
  assign if_c.bus_rdata  = t_rdata;

  logic        o_ready, o_bus_req, o_rsp_valid, o_rsp_fault;
  logic [63:0] o_bus_addr, o_rsp_data;
  logic [7:0]  o_strobe;

  always_comb begin
    case (sel)
      0: begin
        o_ready = if_a.req_ready; o_bus_req = if_a.bus_req;
        o_bus_addr = 64'(if_a.bus_addr); o_strobe = 8'(if_a.bus_strobe);
        o_rsp_valid = if_a.rsp_valid; o_rsp_fault = if_a.rsp_fault; o_rsp_data = 64'(if_a.rsp_data);
      end
      1: begin
        o_ready = if_b.req_ready; o_bus_req = if_b.bus_req;
        o_bus_addr = 64'(if_b.bus_addr); o_strobe = 8'(if_b.bus_strobe);
        o_rsp_valid = if_b.rsp_valid; o_rsp_fault = if_b.rsp_fault; o_rsp_data = 64'(if_b.rsp_data);
      end
      default: begin
        o_ready = if_c.req_ready; o_bus_req = if_c.bus_req;
        o_bus_addr = if_c.bus_addr; o_strobe = if_c.bus_strobe;
        o_rsp_valid = if_c.rsp_valid; o_rsp_fault = if_c.rsp_fault; o_rsp_data = if_c.rsp_data;
      end
    endcase
  end

  int unsigned n_chk, n_pass;
  logic [63:0] last_rsp;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Byte-addressed memory; untouched bytes are filled randomly on first read
  logic [7:0] mem [longint unsigned];

  function automatic logic [7:0] mem_rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic set_word(input logic [63:0] a, input logic [63:0] w, input int nb);
    for (int j = 0; j < nb; j++) mem[a + 64'(j)] = w[8*j +: 8];
  endtask

  function automatic logic [63:0] bus_word(input logic [63:0] a, input int nb);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < nb; j++) r[8*j +: 8] = mem_rd(a + 64'(j));
    return r;
  endfunction

  // Reference: which bytes the load touches, how beats cover them, and the value
  task automatic ref_load(input int s, input logic [63:0] addr, input logic [2:0] f3,
                          output bit fault, output int nbeats,
                          output logic [63:0] a0, output logic [63:0] a1,
                          output logic [7:0] s0, output logic [7:0] s1,
                          output logic [63:0] res);
    int xl, w, size, off;
    bit legal, split;
    xl    = (s == 2) ? 64 : 32;
    w     = xl / 8;
    size  = 1 << f3[1:0];
    off   = int'(addr % 64'(w));
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (xl == 64 && (f3 inside {3'd3, 3'd6}));
    split = (off + size) > w;
    fault = !legal || (split && s == 1);
    nbeats = split ? 2 : 1;
    a0 = addr - 64'(off);
    a1 = a0 + 64'(w);
    s0 = '0;
    s1 = '0;
    for (int j = 0; j < w; j++) begin
      if (a0 + 64'(j) >= addr && a0 + 64'(j) < addr + 64'(size)) s0[j] = 1'b1;
      if (a1 + 64'(j) >= addr && a1 + 64'(j) < addr + 64'(size)) s1[j] = 1'b1;
    end
    res = '0;
    if (!fault) begin
      for (int i = 0; i < size; i++) res[8*i +: 8] = mem_rd(addr + 64'(i));
      if (!f3[2] && res[8*size-1]) for (int i = 8 * size; i < xl; i++) res[i] = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    t_req_valid = 0; t_flush = 0; t_gnt = 0; t_rvalid = 0;
    t_rdata = {$urandom, $urandom};
  endtask

  // One load with a reactive bus; fast = grant at once and data the cycle after
  task automatic run_load(input int s, input logic [63:0] addr, input logic [2:0] f3, input bit fast);
    bit fault, done;
    int nbeats, seen, gnt_wait, rv_cnt, w;
    logic [63:0] a0, a1, res, beat_a, exp_a;
    logic [7:0] s0, s1;
    sel = s;
    w = (s == 2) ? 8 : 4;
    ref_load(s, addr, f3, fault, nbeats, a0, a1, s0, s1, res);
    @(negedge clk);
    chk("ready_before", 64'(o_ready), 64'(1));
    t_req_valid = 1; t_addr = addr; t_f3 = f3;
    seen = 0; done = 0; rv_cnt = -1; beat_a = a0;
    gnt_wait = fast ? 0 : int'($urandom_range(0, 2));
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      idle_inputs();
      if (o_rsp_valid) begin
        chk("rsp_fault", 64'(o_rsp_fault), 64'(fault));
        chk("rsp_data", o_rsp_data, res);
        chk("beat_count", 64'(seen), fault ? 64'(0) : 64'(nbeats));
        if (fast) chk("rsp_latency", 64'(k), fault ? 64'(1) : (nbeats == 2 ? 64'(5) : 64'(3)));
        last_rsp = o_rsp_data;
        done = 1;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            t_rvalid = 1;
            t_rdata  = bus_word(beat_a, w);
            rv_cnt   = -1;
          end
        end
        if (o_bus_req) begin
          exp_a = (seen == 0) ? a0 : a1;
          chk("bus_addr", o_bus_addr, exp_a);
          chk("bus_strobe", 64'(o_strobe), (seen == 0) ? 64'(s0) : 64'(s1));
          if (gnt_wait == 0) begin
            t_gnt    = 1;
            beat_a   = exp_a;
            seen++;
            rv_cnt   = fast ? 1 : int'($urandom_range(1, 3));
            gnt_wait = fast ? 0 : int'($urandom_range(0, 2));
          end else begin
            gnt_wait--;
          end
        end
      end
    end
    if (!done) chk("rsp_timeout", 64'(0), 64'(1));
    @(negedge clk);
    idle_inputs();
    chk("ready_after", 64'(o_ready), 64'(1));
    chk("rsp_one_cycle", 64'(o_rsp_valid), 64'(0));
  endtask

  task automatic start_req(input int s, input logic [63:0] addr, input logic [2:0] f3);
    sel = s;
    @(negedge clk);
    t_req_valid = 1; t_addr = addr; t_f3 = f3;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 0; rst_n = 0; sel = 0; n_chk = 0; n_pass = 0; last_rsp = '0;
    t_addr = '0; t_f3 = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_bus_req", 64'(o_bus_req), 64'(0));
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
      chk("rst_rsp_fault", 64'(o_rsp_fault), 64'(0));
      chk("rst_rsp_data", o_rsp_data, 64'(0));
      chk("rst_bus_addr", o_bus_addr, 64'(0));
      chk("rst_strobe", 64'(o_strobe), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(1));
    end
    rst_n = 1;

    // Directed loads from the bring-up list
    set_word(64'h1000, 64'h80123456, 4);
    run_load(0, 64'h1003, 3'b000, 1'b1);
    chk("lb_const", last_rsp, 64'hFFFFFF80);
    run_load(0, 64'h1003, 3'b100, 1'b1);
    chk("lbu_const", last_rsp, 64'h00000080);
    set_word(64'h1000, 64'hBBAA1111, 4);
    set_word(64'h1004, 64'h2222DDCC, 4);
    run_load(0, 64'h1002, 3'b010, 1'b1);
    chk("lw_split_const", last_rsp, 64'hDDCCBBAA);
    set_word(64'h1000, 64'h00000000, 4);
    set_word(64'h1004, 64'h00000080, 4);
    run_load(0, 64'h1003, 3'b001, 1'b1);
    chk("lh_split_const", last_rsp, 64'hFFFF8000);
    run_load(0, 64'h1003, 3'b101, 1'b1);
    chk("lhu_split_const", last_rsp, 64'h00008000);
    run_load(1, 64'h1003, 3'b001, 1'b1);
    run_load(0, 64'h1000, 3'b011, 1'b1);
    run_load(0, 64'h1000, 3'b110, 1'b1);
    run_load(2, 64'h2005, 3'b011, 1'b1);
    run_load(2, 64'h2004, 3'b110, 1'b1);

    // Flush in WAIT0, data two cycles later: dropped, unit busy until after rvalid
    start_req(0, 64'h1000, 3'b010);
    chk("fw_bus_req", 64'(o_bus_req), 64'(1));
    t_gnt = 1;
    @(negedge clk); idle_inputs(); t_flush = 1;
    @(negedge clk); idle_inputs();
    chk("fw_ready_drain", 64'(o_ready), 64'(0));
    @(negedge clk); idle_inputs(); t_rvalid = 1;
    chk("fw_ready_wait", 64'(o_ready), 64'(0));
    chk("fw_no_rsp", 64'(o_rsp_valid), 64'(0));
    @(negedge clk); idle_inputs();
    chk("fw_ready_back", 64'(o_ready), 64'(1));
    chk("fw_no_rsp2", 64'(o_rsp_valid), 64'(0));
    run_load(0, 64'h1002, 3'b010, 1'b0);

    // Flush in REQ0 with no grant: bus_req drops, back to idle
    start_req(0, 64'h1004, 3'b010);
    chk("fr_bus_req", 64'(o_bus_req), 64'(1));
    t_flush = 1;
    @(negedge clk); idle_inputs();
    chk("fr_bus_req_drop", 64'(o_bus_req), 64'(0));
    chk("fr_ready", 64'(o_ready), 64'(1));

    // Flush with grant in the same cycle: drain the outstanding beat
    start_req(2, 64'h2000, 3'b011);
    t_gnt = 1; t_flush = 1;
    @(negedge clk); idle_inputs();
    chk("fg_ready_drain", 64'(o_ready), 64'(0));
    chk("fg_bus_req", 64'(o_bus_req), 64'(0));
    t_rvalid = 1;
    @(negedge clk); idle_inputs();
    chk("fg_ready", 64'(o_ready), 64'(1));
    chk("fg_no_rsp", 64'(o_rsp_valid), 64'(0));

    // Flush in idle blocks the same-cycle request
    sel = 0;
    @(negedge clk);
    t_req_valid = 1; t_flush = 1; t_addr = 64'h1000; t_f3 = 3'b010;
    @(negedge clk); idle_inputs();
    chk("fi_ready", 64'(o_ready), 64'(1));
    chk("fi_bus_req", 64'(o_bus_req), 64'(0));

    // Flush on the response cycle masks the pulse
    start_req(0, 64'h1003, 3'b000);
    t_gnt = 1;
    @(negedge clk); idle_inputs();
    t_rvalid = 1; t_rdata = bus_word(64'h1000, 4);
    @(negedge clk); idle_inputs();
    t_flush = 1;
    #1;
    chk("fresp_masked", 64'(o_rsp_valid), 64'(0));
    @(negedge clk); idle_inputs();
    chk("fresp_ready", 64'(o_ready), 64'(1));

    // Reset during WAIT1 of a split ld
    start_req(2, 64'h2005, 3'b011);
    t_gnt = 1;
    @(negedge clk); idle_inputs();
    t_rvalid = 1; t_rdata = bus_word(64'h2000, 8);
    @(negedge clk); idle_inputs();
    chk("rw_req1_addr", o_bus_addr, 64'h2008);
    chk("rw_req1_strobe", 64'(o_strobe), 64'h1F);
    t_gnt = 1;
    @(negedge clk); idle_inputs();
    rst_n = 0;
    #1;
    chk("rw_bus_req", 64'(o_bus_req), 64'(0));
    chk("rw_bus_addr", o_bus_addr, 64'(0));
    chk("rw_strobe", 64'(o_strobe), 64'(0));
    chk("rw_rsp_data", o_rsp_data, 64'(0));
    chk("rw_rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("rw_ready", 64'(o_ready), 64'(1));
    @(negedge clk);
    rst_n = 1; t_rvalid = 1; t_rdata = bus_word(64'h2008, 8);
    @(negedge clk); idle_inputs();
    chk("rw_no_rsp", 64'(o_rsp_valid), 64'(0));
    chk("rw_idle", 64'(o_ready), 64'(1));

    // Randomized loads across configurations, alignments and funct3 values
    for (int n = 0; n < 300; n++) begin
      run_load(int'($urandom_range(0, 2)), 64'h3000 + 64'($urandom_range(0, 63)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Sequential successor to the combinational load data formatter. Issues load beats to the data bus and merges them. Splits misaligned loads that cross a bus word into two beats. Applies byte/half/word/double extraction with sign or zero extension. Sits between the MEM stage and the data-memory port, with one load outstanding at a time.

Parameters:
XLEN, 32, datapath and address width. Legal values are 32 or 64.
MISALIGNED_EN, 1, 1 = split word-crossing loads into two beats; 0 = fault them.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  load request from MEM stage
req_ready  out  1  unit can accept a request
req_addr  in  XLEN  byte address
req_funct3  in  3  RISC-V load funct3
flush  in  1  kill the in-flight load
bus_req  out  1  bus beat request
bus_addr  out  XLEN  beat address, aligned to XLEN/8
bus_strobe  out  XLEN/8  byte lanes read in this beat
bus_gnt  in  1  beat accepted
bus_rvalid  in  1  read data valid
bus_rdata  in  XLEN  read data
rsp_valid  out  1  one-cycle result pulse
rsp_data  out  XLEN  extended load result
rsp_fault  out  1  illegal funct3, or misaligned load when MISALIGNED_EN=0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - bus_req, rsp_valid and rsp_fault are 0; rsp_data, bus_addr and bus_strobe are 0.
  - A reset during any state abandons the load with no response.
- Handshakes:
  - req_ready=1 only in IDLE. A request is accepted when req_valid&&req_ready; addr and funct3 are registered.
  - A beat completes when bus_req&&bus_gnt. bus_addr and bus_strobe are held stable until gnt.
  - bus_rvalid is ignored outside the WAIT and DRAIN states.
- Size:
  - 000/100 = 1 byte; 001/101 = 2 bytes; 010 = 4 bytes.
  - 011 (ld) and 110 (lwu) = 8 and 4 bytes respectively, legal only when XLEN=64.
  - funct3[2]=1 means zero-extend; otherwise sign-extend.
  - ld has no extension.
- Lane maths:
  - W = XLEN/8; off = addr mod W.
  - split = (off+size > W).
  - Beat 0: addr & ~(W-1); strobe has bits off .. min(off+size, W)-1 set.
  - Beat 1: beat-0 address + W; strobe has bits 0 .. off+size-W-1 set.
  - Merge: take {rdata1, rdata0} >> (8*off), keep the low size bytes, then extend to XLEN.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN.
  - IDLE -> REQ0 on accept of a legal request.
  - IDLE -> RESP with fault on an illegal funct3, or on split with MISALIGNED_EN=0. No bus activity; rsp_data=0.
  - REQ0 -> WAIT0 on gnt.
  - WAIT0 -> REQ1 on rvalid if split; otherwise WAIT0 -> RESP. rdata0 is captured.
  - REQ1 -> WAIT1 on gnt.
  - WAIT1 -> RESP on rvalid.
  - RESP: rsp_valid=1 for exactly one cycle, data registered, then -> IDLE.
- Latency:
  - Accept at cycle T. If gnt comes the same cycle as req and rvalid comes the next cycle, bus_req is asserted at T+1 and rsp_valid at T+3 for a single beat, T+5 for a split.
  - Fault response: rsp_valid at T+1.
- Flush:
  - In REQ0/REQ1 without gnt the same cycle: -> IDLE, bus_req drops, no response.
  - In REQ0/REQ1 with gnt the same cycle: -> DRAIN.
  - In WAIT0/WAIT1: -> DRAIN.
  - DRAIN waits for the outstanding rvalid, discards it, then -> IDLE. Response is suppressed.
  - flush in RESP: rsp_valid is forced to 0.
  - flush in IDLE: no effect, and the same-cycle request is not accepted.
- rsp_fault is only meaningful with rsp_valid and is 0 otherwise.

Test Plan:
- XLEN=32, lb @0x1003, rdata=0x80123456 -> bus_addr 0x1000, strobe 1000, rsp 0xFFFFFF80. lbu same -> 0x00000080.
- lw @0x1002, beat0 rdata 0xBBAA1111, beat1 rdata 0x2222DDCC -> beat0 0x1000/1100, beat1 0x1004/0011, rsp 0xDDCCBBAA, rsp_valid at T+5.
- lh @0x1003, beat0 rdata 0x00000000, beat1 rdata 0x00000080 -> rsp 0xFFFF8000; lhu -> 0x00008000. With MISALIGNED_EN=0 -> rsp_fault=1, no bus_req.
- XLEN=32, funct3=011 -> rsp_fault=1, rsp_data 0 at T+1, bus_req never asserted; req_ready high at T+2.
- flush in WAIT0, rvalid two cycles later -> rsp_valid never asserts, req_ready stays 0 until the cycle after rvalid; the next load returns correct data.
- XLEN=64, ld @0x2005 -> beats 0x2000/0xE0 and 0x2008/0x1F, merged 64-bit result. rst_n low during WAIT1 -> all outputs 0 immediately, IDLE, no response.
